// File: rtl/event_pkg.sv
// Shared FSM state type and word-level constants for the event packer.
// The CSUM state exists only when EVENT_PACKER_CHECKSUM_EN is defined.
package event_pkg;

  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] HDR_MARK_DEFAULT = 8'hA5;
  localparam logic [WORD_W-1:0] DROP_SAT = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_EVNUM = 3'd2,
    ST_DATA  = 3'd3
`ifdef EVENT_PACKER_CHECKSUM_EN
    ,
    ST_CSUM  = 3'd4
`endif
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_packer_if.sv
// Record-word stream from the packer to the downstream FIFO (valid/ready).
interface event_packer_if;
  import event_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/event_packer_fsm.sv
// Record sequencer: state register, tube index and next-state logic.
// Advances one word per accepted handshake; holds position while not accepted.
module packer_fsm
  import event_pkg::*;
#(
  parameter int NUM_TUBES = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_i,
  input  logic             accept_i,
  output state_e           state_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             last_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_last;

  assign idx_last = (idx_q == IDX_W'(NUM_TUBES - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_MARK;
      ST_MARK:  if (accept_i) state_d = ST_EVNUM;
      ST_EVNUM: begin
        if (accept_i) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (accept_i) begin
          if (idx_last) begin
            idx_d = '0;
`ifdef EVENT_PACKER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef EVENT_PACKER_CHECKSUM_EN
      ST_CSUM:  if (accept_i) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q != ST_IDLE);
    busy_o  = (state_q != ST_IDLE);
`ifdef EVENT_PACKER_CHECKSUM_EN
    last_o  = accept_i && (state_q == ST_CSUM);
`else
    last_o  = accept_i && (state_q == ST_DATA) && idx_last;
`endif
  end

  assign state_o = state_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/event_packer.sv
// Snapshots tube counts on evt_done and emits MARK, EVNUM, tube bytes; first word 1 cycle later.
// Words hold while out_ready is low; EVENT_PACKER_CHECKSUM_EN appends an XOR checksum word.
module event_packer
  import event_pkg::*;
#(
  parameter int                NUM_TUBES = 8,
  parameter logic [WORD_W-1:0] HDR_MARK  = HDR_MARK_DEFAULT
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [NUM_TUBES*WORD_W-1:0] tube_data,
  input  logic                        evt_done,
  event_packer_if.master              out_if,
  output logic                        tube_clr,
  output logic                        busy,
  output logic [WORD_W-1:0]           drop_cnt
);

  localparam int IDX_W = idx_width(NUM_TUBES);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             accept;
  logic             start;
  logic             rec_done;
  logic [WORD_W-1:0] word;

  logic [NUM_TUBES-1:0][WORD_W-1:0] snap_q, snap_d;
  logic [WORD_W-1:0]                evnum_q, evnum_d;
  logic [WORD_W-1:0]                drop_q, drop_d;
  logic                             tube_clr_q, tube_clr_d;

  assign accept = valid & out_if.out_ready;
  assign start  = evt_done & ~busy;

  packer_fsm #(
    .NUM_TUBES (NUM_TUBES),
    .IDX_W     (IDX_W)
  ) u_fsm (
    .clk      (clk),
    .clr      (clr),
    .start_i  (start),
    .accept_i (accept),
    .state_o  (state),
    .idx_o    (idx),
    .valid_o  (valid),
    .busy_o   (busy),
    .last_o   (rec_done)
  );

  // Pulses arriving while busy, including on the last-word edge, are drops.
  always_comb begin
    snap_d     = snap_q;
    evnum_d    = evnum_q;
    drop_d     = drop_q;
    tube_clr_d = start;
    if (start)    snap_d  = tube_data;
    if (rec_done) evnum_d = evnum_q + 1'b1;
    if (evt_done && busy && (drop_q != DROP_SAT)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      snap_q     <= '0;
      evnum_q    <= '0;
      drop_q     <= '0;
      tube_clr_q <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      evnum_q    <= evnum_d;
      drop_q     <= drop_d;
      tube_clr_q <= tube_clr_d;
    end
  end

`ifdef EVENT_PACKER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start)       csum_d = '0;
    else if (accept) csum_d = csum_q ^ word;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  always_comb begin
    word = '0;
    case (state)
      ST_MARK:  word = HDR_MARK;
      ST_EVNUM: word = evnum_q;
      ST_DATA:  word = snap_q[idx];
`ifdef EVENT_PACKER_CHECKSUM_EN
      ST_CSUM:  word = csum_q;
`endif
      default:  word = '0;
    endcase
  end

  assign out_if.out_data  = word;
  assign out_if.out_valid = valid;
  assign tube_clr         = tube_clr_q;
  assign drop_cnt         = drop_q;

endmodule
